// File: rtl/demux_16_12_stream_pkg.sv
// Shared definitions for the 1-to-2 streaming demux.
// Default widths and the per-port slot state encoding.
package demux_16_12_stream_pkg;

  localparam int WIDTH = 16;
  localparam int CNT_W = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/demux_port_slot.sv
// One-entry output slot with a completed-transfer counter.
// A load may coincide with a drain; the new word replaces the old.
module demux_port_slot #(
  parameter int WIDTH = demux_16_12_stream_pkg::WIDTH,
  parameter int CNT_W = demux_16_12_stream_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out_ready,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic [CNT_W-1:0] cnt
);
  import demux_16_12_stream_pkg::*;

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             xfer_out;

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign cnt       = cnt_q;
  assign xfer_out  = out_valid & out_ready;

  // Next slot state and held word
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load) begin
      state_d = FULL;
      data_d  = in_data;
    end else if (xfer_out) begin
      state_d = EMPTY;
    end
  end

  // Next transfer count; a clear drops the same-cycle transfer
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (xfer_out) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/demux_16_12_stream.sv
// Routes one valid/ready input stream to one of two output slots.
// Only the selected slot gates in_ready.
module demux_16_12_stream #(
  parameter int WIDTH = demux_16_12_stream_pkg::WIDTH,
  parameter int CNT_W = demux_16_12_stream_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic             busy
);
  import demux_16_12_stream_pkg::*;

  logic rdy0, rdy1;
  logic load0, load1;

  // Accept decode and per-port load enables
  always_comb begin
    rdy0     = ~out0_valid | out0_ready;
    rdy1     = ~out1_valid | out1_ready;
    in_ready = in_sel ? rdy1 : rdy0;
    load0    = in_valid & in_ready & ~in_sel;
    load1    = in_valid & in_ready & in_sel;
  end

  assign busy = out0_valid | out1_valid;

  demux_port_slot #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_slot0 (
    .clk      (clk),
    .rst      (rst),
    .load     (load0),
    .in_data  (in_data),
    .out_ready(out0_ready),
    .cnt_clr  (cnt_clr),
    .out_data (out0_data),
    .out_valid(out0_valid),
    .cnt      (cnt0)
  );

  demux_port_slot #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_slot1 (
    .clk      (clk),
    .rst      (rst),
    .load     (load1),
    .in_data  (in_data),
    .out_ready(out1_ready),
    .cnt_clr  (cnt_clr),
    .out_data (out1_data),
    .out_valid(out1_valid),
    .cnt      (cnt1)
  );

endmodule

// File: tb/tb_demux_16_12_stream.sv
// Scoreboard bench for demux_16_12_stream.
// Stimulus pushes expected words; a negedge monitor pops on output transfers.
module tb_demux_16_12_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out0_data;
  logic        out0_valid;
  logic        out0_ready;
  logic [15:0] out1_data;
  logic        out1_valid;
  logic        out1_ready;
  logic        cnt_clr;
  logic [7:0]  cnt0;
  logic [7:0]  cnt1;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;

  logic [15:0] q0[$];
  logic [15:0] q1[$];

  always #5 clk = ~clk;

  demux_16_12_stream dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out0_data (out0_data),
    .out0_valid(out0_valid),
    .out0_ready(out0_ready),
    .out1_data (out1_data),
    .out1_valid(out1_valid),
    .out1_ready(out1_ready),
    .cnt_clr   (cnt_clr),
    .cnt0      (cnt0),
    .cnt1      (cnt1),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a word; check in_ready against the model and queue it if taken
  task automatic send(input logic [15:0] d, input logic s,
                      input logic exp_rdy);
    in_data  = d;
    in_sel   = s;
    in_valid = 1'b1;
    @(negedge clk);
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    if (exp_rdy) begin
      if (s) q1.push_back(d);
      else   q0.push_back(d);
    end
  endtask

  // Monitor: compare every output transfer against the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (out0_valid && out0_ready) begin
        if (q0.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL port0_unexpected: got %0h expected none", out0_data);
        end else begin
          chk("port0_data", {16'd0, out0_data}, {16'd0, q0.pop_front()});
        end
      end
      if (out1_valid && out1_ready) begin
        if (q1.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL port1_unexpected: got %0h expected none", out1_data);
        end else begin
          chk("port1_data", {16'd0, out1_data}, {16'd0, q1.pop_front()});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    in_data = '0;
    in_sel = 1'b0;
    in_valid = 1'b0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    cnt_clr = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_v0", {31'd0, out0_valid}, 32'd0);
    chk("rst_v1", {31'd0, out1_valid}, 32'd0);
    chk("rst_d0", {16'd0, out0_data}, 32'd0);
    chk("rst_d1", {16'd0, out1_data}, 32'd0);
    chk("rst_c0", {24'd0, cnt0}, 32'd0);
    chk("rst_c1", {24'd0, cnt1}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    in_sel = 1'b0;
    #1 chk("rst_rdy_s0", {31'd0, in_ready}, 32'd1);
    in_sel = 1'b1;
    #1 chk("rst_rdy_s1", {31'd0, in_ready}, 32'd1);

    // single load to port 0
    send(16'hA5A5, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("l0_v0", {31'd0, out0_valid}, 32'd1);
    chk("l0_d0", {16'd0, out0_data}, 32'h0000A5A5);
    chk("l0_v1", {31'd0, out1_valid}, 32'd0);
    chk("l0_busy", {31'd0, busy}, 32'd1);

    // drain port 0; data is retained after draining
    out0_ready = 1'b1;
    tick();
    out0_ready = 1'b0;
    chk("dr_v0", {31'd0, out0_valid}, 32'd0);
    chk("dr_c0", {24'd0, cnt0}, 32'd1);
    chk("dr_d0_hold", {16'd0, out0_data}, 32'h0000A5A5);

    // port 1 full and stalled blocks only its own traffic
    send(16'hBEEF, 1'b1, 1'b1);
    tick();
    send(16'h1234, 1'b1, 1'b0);
    tick();
    chk("blk_d1", {16'd0, out1_data}, 32'h0000BEEF);
    chk("blk_v1", {31'd0, out1_valid}, 32'd1);
    send(16'h1234, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("alt_d0", {16'd0, out0_data}, 32'h00001234);
    chk("alt_d1", {16'd0, out1_data}, 32'h0000BEEF);
    chk("alt_c1", {24'd0, cnt1}, 32'd0);

    // drain with cnt_clr: transfer not counted
    out0_ready = 1'b1;
    cnt_clr = 1'b1;
    tick();
    out0_ready = 1'b0;
    cnt_clr = 1'b0;
    chk("clr_c0", {24'd0, cnt0}, 32'd0);
    chk("clr_v0", {31'd0, out0_valid}, 32'd0);

    // simultaneous drain and load on port 0
    send(16'h0001, 1'b0, 1'b1);
    tick();
    out0_ready = 1'b1;
    send(16'h0002, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    out0_ready = 1'b0;
    chk("pt_v0", {31'd0, out0_valid}, 32'd1);
    chk("pt_d0", {16'd0, out0_data}, 32'h00000002);
    chk("pt_c0", {24'd0, cnt0}, 32'd1);

    // both ports drain in one cycle
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    tick();
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    chk("both_v0", {31'd0, out0_valid}, 32'd0);
    chk("both_v1", {31'd0, out1_valid}, 32'd0);
    chk("both_c0", {24'd0, cnt0}, 32'd2);
    chk("both_c1", {24'd0, cnt1}, 32'd1);
    chk("both_busy", {31'd0, busy}, 32'd0);

    // counter wrap: 256 words through port 1
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("wr_clr_c1", {24'd0, cnt1}, 32'd0);
    out1_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      send(16'(i), 1'b1, 1'b1);
      tick();
    end
    in_valid = 1'b0;
    chk("wr_c1_255", {24'd0, cnt1}, 32'd255);
    tick();
    out1_ready = 1'b0;
    chk("wr_c1_0", {24'd0, cnt1}, 32'd0);
    chk("wr_v1", {31'd0, out1_valid}, 32'd0);
    chk("wr_d0_iso", {16'd0, out0_data}, 32'h00000002);
    chk("wr_c0_iso", {24'd0, cnt0}, 32'd0);

    // cnt_clr on a port 1 transfer cycle
    send(16'h5555, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("cc_c1_pre", {24'd0, cnt1}, 32'd0);
    out1_ready = 1'b1;
    cnt_clr = 1'b1;
    tick();
    out1_ready = 1'b0;
    cnt_clr = 1'b0;
    chk("cc_c1", {24'd0, cnt1}, 32'd0);
    chk("cc_v1", {31'd0, out1_valid}, 32'd0);
    send(16'h6666, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    out1_ready = 1'b1;
    tick();
    out1_ready = 1'b0;
    chk("cc_c1_resume", {24'd0, cnt1}, 32'd1);

    // reset mid-operation discards both held words
    send(16'hAAAA, 1'b0, 1'b1);
    tick();
    send(16'hBBBB, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("pr_busy", {31'd0, busy}, 32'd1);
    chk("pr_q0", q0.size(), 32'd1);
    chk("pr_q1", q1.size(), 32'd1);
    rst = 1'b1;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    tick();
    rst = 1'b0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    q0.delete();
    q1.delete();
    chk("mr_v0", {31'd0, out0_valid}, 32'd0);
    chk("mr_v1", {31'd0, out1_valid}, 32'd0);
    chk("mr_d0", {16'd0, out0_data}, 32'd0);
    chk("mr_d1", {16'd0, out1_data}, 32'd0);
    chk("mr_c0", {24'd0, cnt0}, 32'd0);
    chk("mr_c1", {24'd0, cnt1}, 32'd0);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    in_sel = 1'b0;
    #1 chk("mr_rdy_s0", {31'd0, in_ready}, 32'd1);
    in_sel = 1'b1;
    #1 chk("mr_rdy_s1", {31'd0, in_ready}, 32'd1);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
